// File: rtl/ctrl_pkg.sv
// Shared state encoding for the control sequencer and the downstream control decoder.
// S1..S8 use their external 3-bit codes; WAIT lives outside that range.
package ctrl_pkg;

    localparam int STATE_W = 4;
    localparam int CODE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_ALLOC  = 4'd0,
        ST_LOAD   = 4'd1,
        ST_CONV   = 4'd2,
        ST_RES    = 4'd3,
        ST_ERR    = 4'd4,
        ST_OUT    = 4'd5,
        ST_NEW_IN = 4'd6,
        ST_NEXT   = 4'd7,
        ST_WAIT   = 4'd8
    } state_t;

    // WAIT reports code 000 with lut_en low, so decoders must qualify with state_active.
    function automatic logic [CODE_W-1:0] state_code(input state_t s);
        return (s == ST_WAIT) ? '0 : s[CODE_W-1:0];
    endfunction

    function automatic logic state_active(input state_t s);
        return s != ST_WAIT;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Handshake and status bundle between the sequencer (slave) and its environment (master).
interface ctrl_sequencer_if;
    import ctrl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              alloc_last;
    logic              out_ready;
    logic [CODE_W-1:0] fsm_state;
    logic              lut_en;
    logic              frame_done;
    logic              ovf;

    modport master (
        output in_valid, alloc_last, out_ready,
        input  in_ready, fsm_state, lut_en, frame_done, ovf
    );

    modport slave (
        input  in_valid, alloc_last, out_ready,
        output in_ready, fsm_state, lut_en, frame_done, ovf
    );

endinterface

// File: rtl/ctrl_tap_cnt.sv
// Loadable down-counter that times the MAC convolution phase; saturates at zero.
module ctrl_tap_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ctrl_sequencer.sv
// Per-sample control sequencer: accept, allocate, convolve for TAPS cycles, emit up to OUT_MAX outputs.
// Optional error stage S5 is enabled by defining CTRL_ERR_STAGE_EN.
module ctrl_sequencer #(
    parameter int TAPS    = 16,
    parameter int OUT_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_sequencer_if.slave   bus
);
    import ctrl_pkg::*;

    localparam int TAP_W = 8;
    localparam int OUT_W = 5;
    localparam logic [TAP_W-1:0] TAP_LOAD = TAP_W'(TAPS - 1);
    localparam logic [OUT_W-1:0] OUT_LIM  = OUT_W'(OUT_MAX);

    state_t           state;
    state_t           state_nxt;
    logic             tap_zero;
    logic [OUT_W-1:0] out_cnt;
    logic [OUT_W-1:0] out_cnt_inc;
    logic             limit_hit;
    logic             ovf;

    assign out_cnt_inc = out_cnt + 1'b1;
    assign limit_hit   = (out_cnt_inc >= OUT_LIM);

    ctrl_tap_cnt #(.CNT_W(TAP_W)) u_tap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_LOAD),
        .dec      (state == ST_CONV),
        .load_val (TAP_LOAD),
        .zero     (tap_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT:   if (bus.in_valid && bus.in_ready) state_nxt = ST_NEW_IN;
            ST_NEW_IN: state_nxt = ST_ALLOC;
            ST_ALLOC:  state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_CONV;
            ST_CONV:   if (tap_zero) state_nxt = ST_RES;
`ifdef CTRL_ERR_STAGE_EN
            ST_RES:    state_nxt = ST_ERR;
            ST_ERR:    state_nxt = ST_OUT;
`else
            ST_RES:    state_nxt = ST_OUT;
`endif
            ST_OUT:    if (bus.out_ready) state_nxt = ST_NEXT;
            ST_NEXT:   state_nxt = (bus.alloc_last || limit_hit) ? ST_WAIT : ST_ALLOC;
            // Unreachable codes (including S5 when the error stage is compiled out) fall back to idle.
            default:   state_nxt = ST_WAIT;
        endcase
    end

    always_comb begin
        bus.in_ready   = (state == ST_WAIT);
        bus.lut_en     = state_active(state);
        bus.fsm_state  = state_code(state);
        bus.frame_done = (state == ST_NEXT) && (state_nxt == ST_WAIT);
    end

    // alloc_last takes priority over the limit, so ovf only flags truncated allocation lists.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            if ((state == ST_WAIT) && (state_nxt == ST_NEW_IN)) begin
                out_cnt <= '0;
            end else if (state == ST_NEXT) begin
                out_cnt <= out_cnt_inc;
            end
            if ((state == ST_NEXT) && !bus.alloc_last && limit_hit) begin
                ovf <= 1'b1;
            end
        end
    end

    assign bus.ovf = ovf;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: frame timing, stall, multi-pass, overflow and reset recovery.
module tb_ctrl_sequencer;

    localparam int TAPS    = 16;
    localparam int OUT_MAX = 4;

    localparam logic [2:0] C_S1 = 3'd0, C_S2 = 3'd1, C_S3 = 3'd2, C_S4 = 3'd3;
    localparam logic [2:0] C_S5 = 3'd4, C_S6 = 3'd5, C_S7 = 3'd6, C_S8 = 3'd7;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ctrl_sequencer_if bus ();

    ctrl_sequencer #(.TAPS(TAPS), .OUT_MAX(OUT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] code, input logic lut, input logic fd);
        chk({tag, ".fsm_state"}, 8'(bus.fsm_state), 8'(code));
        chk({tag, ".lut_en"}, 8'(bus.lut_en), 8'(lut));
        chk({tag, ".frame_done"}, 8'(bus.frame_done), 8'(fd));
    endtask

    task automatic chk_wait(input string tag);
        chk_state(tag, 3'd0, 1'b0, 1'b0);
        chk({tag, ".in_ready"}, 8'(bus.in_ready), 8'd1);
    endtask

    // From WAIT: pulse in_valid and step to S1.
    task automatic accept(input string tag);
        chk({tag, ".accept_ready"}, 8'(bus.in_ready), 8'd1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk_state({tag, ".S7"}, C_S7, 1'b1, 1'b0);
        chk({tag, ".S7_ready"}, 8'(bus.in_ready), 8'd0);
        tick();
        chk_state({tag, ".S1"}, C_S1, 1'b1, 1'b0);
    endtask

    // From S1: S2, exactly TAPS cycles of S3, then S4.
    task automatic conv_pass(input string tag);
        tick();
        chk_state({tag, ".S2"}, C_S2, 1'b1, 1'b0);
        for (int i = 0; i < TAPS; i++) begin
            tick();
            chk_state($sformatf("%s.S3_%0d", tag, i), C_S3, 1'b1, 1'b0);
        end
        tick();
        chk_state({tag, ".S4"}, C_S4, 1'b1, 1'b0);
    endtask

    task automatic res_to_s6(input string tag);
`ifdef CTRL_ERR_STAGE_EN
        tick();
        chk_state({tag, ".S5"}, C_S5, 1'b1, 1'b0);
`endif
        tick();
        chk_state({tag, ".S6"}, C_S6, 1'b1, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.alloc_last = 1'b0;
        bus.out_ready  = 1'b1;
        tick();
        tick();
        chk_wait("rst_held");
        chk("rst_held.ovf", 8'(bus.ovf), 8'd0);
        rst = 1'b0;
        tick();
        chk_wait("idle");
        chk("idle.ovf", 8'(bus.ovf), 8'd0);

        // Single-pass frame, alloc_last=1, no stall.
        bus.alloc_last = 1'b1;
        accept("A");
        conv_pass("A");
        res_to_s6("A");
        tick();
        chk_state("A.S8", C_S8, 1'b1, 1'b1);
        tick();
        chk_wait("A.end");
        chk("A.ovf", 8'(bus.ovf), 8'd0);

        // Output stall plus in_valid held during the frame.
        bus.out_ready = 1'b0;
        accept("B");
        bus.in_valid = 1'b1;
        chk("B.busy_ready", 8'(bus.in_ready), 8'd0);
        conv_pass("B");
        bus.in_valid = 1'b0;
        res_to_s6("B");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_state($sformatf("B.stall_%0d", i), C_S6, 1'b1, 1'b0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk_state("B.S8", C_S8, 1'b1, 1'b1);
        tick();
        chk_wait("B.end");

        // Four passes; alloc_last arrives on the 4th, coinciding with the limit.
        bus.alloc_last = 1'b0;
        accept("C");
        for (int p = 0; p < 4; p++) begin
            conv_pass($sformatf("C%0d", p));
            res_to_s6($sformatf("C%0d", p));
            bus.alloc_last = (p == 3);
            tick();
            chk_state($sformatf("C%0d.S8", p), C_S8, 1'b1, 1'(p == 3));
            if (p < 3) begin
                tick();
                chk_state($sformatf("C%0d.loop", p), C_S1, 1'b1, 1'b0);
            end
        end
        tick();
        chk_wait("C.end");
        chk("C.ovf", 8'(bus.ovf), 8'd0);

        // alloc_last never arrives: limit ends the frame and raises ovf.
        bus.alloc_last = 1'b0;
        accept("D");
        for (int p = 0; p < 4; p++) begin
            conv_pass($sformatf("D%0d", p));
            res_to_s6($sformatf("D%0d", p));
            tick();
            chk_state($sformatf("D%0d.S8", p), C_S8, 1'b1, 1'(p == 3));
            tick();
            if (p < 3) begin
                chk_state($sformatf("D%0d.loop", p), C_S1, 1'b1, 1'b0);
                chk($sformatf("D%0d.ovf", p), 8'(bus.ovf), 8'd0);
            end else begin
                chk_wait("D.end");
                chk("D.ovf", 8'(bus.ovf), 8'd1);
            end
        end

        // Output counter restarts per sample; ovf stays sticky.
        accept("E");
        conv_pass("E0");
        res_to_s6("E0");
        tick();
        chk_state("E0.S8", C_S8, 1'b1, 1'b0);
        tick();
        chk_state("E0.loop", C_S1, 1'b1, 1'b0);
        chk("E0.ovf", 8'(bus.ovf), 8'd1);
        conv_pass("E1");
        res_to_s6("E1");
        bus.alloc_last = 1'b1;
        tick();
        chk_state("E1.S8", C_S8, 1'b1, 1'b1);
        tick();
        chk_wait("E.end");
        chk("E.ovf", 8'(bus.ovf), 8'd1);

        // Reset at the 10th S3 cycle.
        accept("F");
        tick();
        chk_state("F.S2", C_S2, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_state($sformatf("F.S3_%0d", i), C_S3, 1'b1, 1'b0);
        end
        rst = 1'b1;
        tick();
        chk_wait("F.rst");
        chk("F.rst_ovf", 8'(bus.ovf), 8'd0);
        rst = 1'b0;
        tick();
        chk_wait("F.post");

        // Fresh sample after reset gets the full convolution.
        accept("G");
        conv_pass("G");
        res_to_s6("G");
        tick();
        chk_state("G.S8", C_S8, 1'b1, 1'b1);
        tick();
        chk_wait("G.end");
        chk("G.ovf", 8'(bus.ovf), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 SHALL have parameter TAPS, default 16, meaning MAC convolution length in cycles; legal range 1..256.
REQ-002 SHALL have parameter OUT_MAX, default 4, meaning the maximum number of output samples per input sample; legal range 1..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a new audio-bus sample is available.
REQ-006 SHALL have port in_ready, output, 1 bit: the sequencer accepts a sample.
REQ-007 SHALL have port alloc_last, input, 1 bit: the current allocation-list entry is the last one for this input sample.
REQ-008 SHALL have port out_ready, input, 1 bit: the system-output consumer accepts a sample.
REQ-009 SHALL have port fsm_state, output, 3 bits: control state code; 000=S1 ALLOC, 001=S2 LOAD, 010=S3 CONV, 011=S4 RES, 100=S5 ERR, 101=S6 OUT, 110=S7 NEW_IN, 111=S8 NEXT.
REQ-010 SHALL have port lut_en, output, 1 bit: fsm_state is active; when low, downstream control decode is ignored.
REQ-011 SHALL have port frame_done, output, 1 bit: single-cycle pulse marking the end of processing for one input sample.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag raised when the OUT_MAX limit is hit.

Function
REQ-013 SHALL implement internal states WAIT plus S1..S8; WAIT drives lut_en=0 and fsm_state=000; every other state drives lut_en=1 and its own code.
REQ-014 SHALL drive in_ready=1 only in WAIT, decoded combinationally from the registered state.
REQ-015 SHALL apply these transitions:
- WAIT: to S7 on in_valid&&in_ready, otherwise stay in WAIT.
- S7: to S1.
- S1: to S2.
- S2: to S3, loading the tap counter with TAPS-1.
- S3: stay while the tap counter is nonzero, decrementing it each cycle; to S4 when it is 0.
- S4: to S5 or S6 (see REQ-023).
- S5: to S6.
- S6: stay while out_ready=0; to S8 when out_ready=1.
- S8: see REQ-016.
REQ-016 SHALL, in S8:
- increment the output counter;
- go to WAIT if alloc_last=1;
- otherwise go to WAIT if the counter has reached OUT_MAX, setting ovf;
- otherwise go to S1.
REQ-017 SHALL hold S3 for exactly TAPS cycles; with TAPS=1, S3 lasts one cycle.
REQ-018 SHALL assert frame_done during the S8 cycle whose next state is WAIT, and only then.
REQ-019 SHALL clear the output counter on entry to S7; alloc_last=1 and the OUT_MAX limit occurring together SHALL leave ovf unchanged (alloc_last wins).
REQ-020 SHALL ignore in_valid in every state other than WAIT; no sample is queued.
REQ-021 SHALL give accept-to-S4 latency of TAPS+4 cycles: acceptance in WAIT at cycle 0, S7 at cycle 1, S1 at 2, S2 at 3, S3 at 4..TAPS+3.

Reset
REQ-022 SHALL, when rst=1 on a clock edge, regardless of state (including mid-S3 or mid-S6 stall), set the following on the next cycle:
- state=WAIT and fsm_state=000;
- lut_en=0 and frame_done=0;
- ovf=0;
- tap counter and output counter cleared;
- in_ready=1 from the first cycle after reset is released.

Configuration
REQ-023 SHALL use macro CTRL_ERR_STAGE_EN:
- when defined, S4 goes to S5 and S5 goes to S6;
- when undefined, S4 goes to S6 directly, S5 is unreachable, and an illegal-state recovery to WAIT SHALL be present for code 100 and any other unreachable state.

Structure
REQ-024 SHALL take the S1..S8 codes, the WAIT internal encoding and the state width from shared package ctrl_pkg, which the control decoder also uses.
REQ-025 SHALL place the loadable down-counter in sub-module ctrl_tap_cnt (ports: load, dec, load value, zero flag).

Verification
REQ-026 SHALL cover: TAPS=16, CTRL_ERR_STAGE_EN defined, in_valid pulse at cycle 0, out_ready=1, alloc_last=1 -> S7@1, S1@2, S2@3, S3@4..19, S4@20, S5@21, S6@22, S8@23 with frame_done=1, WAIT@24.
REQ-027 SHALL cover: same stimulus with the macro undefined -> S4@20, S6@21, S8@22, WAIT@23; code 100 never appears.
REQ-028 SHALL cover: out_ready held 0 for 5 cycles in S6 -> S6 held 5 extra cycles, then S8; in_valid pulses during the frame -> in_ready=0 and no extra S7.
REQ-029 SHALL cover: alloc_last=0 at 3 S8 visits then 1 -> 4 passes S1..S8, single frame_done, ovf=0.
REQ-030 SHALL cover: OUT_MAX=4 with alloc_last held 0 -> WAIT after the 4th S8, frame_done=1, ovf=1 sticky until rst.
REQ-031 SHALL cover: rst asserted at cycle 10 of S3 -> WAIT, lut_en=0, ovf=0 next cycle; a fresh sample afterwards yields the full TAPS-cycle S3.
